multicycle_controller: RTL and testbench

Finite-state controller that sequences the team's multi-cycle RV32 datapath: one shared instruction/data memory, one ALU with a multi-cycle multiply/divide unit, and one register file write port. It replaces single-cycle decode-only control with a fetch/decode/execute/memory/writeback sequence. It handles memory wait states and mul/div completion, and halts on illegal encodings.

---
 rtl/multicycle_controller.sv | 277 +++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Sequencing FSM for the shared-memory multi-cycle RV32 datapath.
// The state moves through fetch, decode, execute, the optional mul/div and
// memory states, and writeback. Illegal encodings stop the controller in HALT.
// The datapath word width is 32 bits. It appears only in this description;
// the controller carries no datapath.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   opcode/func3/func7       instruction register fields
//   alu_flag                 ALU compare flag used for branch resolution
//   alu_done                 mul/div result valid (sampled only in MULDIV)
//   mem_ready                memory accepts/completes the current request
//   Pc_We, Ir_We, Mem_Req,   combinational strobes, all forced low while
//   We_Data_Mem, We_Reg,     rst is high
//   Alu_Start, Addr_Select,
//   Pc_Select
//   Alu_Func, Alu_Select,    decode fields, registered at DECODE->EXEC
//   Imm_Select, Result_Select
//   Illegal                  sticky illegal-instruction flag
//   State                    current state (debug)
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       alu_flag,
  input  logic       alu_done,
  input  logic       mem_ready,
  output logic       Pc_We,
  output logic       Ir_We,
  output logic       Mem_Req,
  output logic       We_Data_Mem,
  output logic       We_Reg,
  output logic       Alu_Start,
  output logic       Addr_Select,
  output logic       Alu_Select,
  output logic       Result_Select,
  output logic       Pc_Select,
  output logic [1:0] Imm_Select,
  output logic [4:0] Alu_Func,
  output logic       Illegal,
  output logic [2:0] State
);

  localparam int unsigned FUNC_W = 5;
  localparam int unsigned IMM_W  = 2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [FUNC_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [FUNC_W-1:0] ALU_SUB  = 5'b00001;
  localparam logic [FUNC_W-1:0] ALU_MUL  = 5'b00010;
  localparam logic [FUNC_W-1:0] ALU_DIV  = 5'b00011;
  localparam logic [FUNC_W-1:0] ALU_AND  = 5'b00100;
  localparam logic [FUNC_W-1:0] ALU_OR   = 5'b00101;
  localparam logic [FUNC_W-1:0] ALU_XOR  = 5'b00110;
  localparam logic [FUNC_W-1:0] ALU_BLT  = 5'b01000;
  localparam logic [FUNC_W-1:0] ALU_SLL  = 5'b01001;
  localparam logic [FUNC_W-1:0] ALU_SRL  = 5'b01010;
  localparam logic [FUNC_W-1:0] ALU_SLT  = 5'b01011;
  localparam logic [FUNC_W-1:0] ALU_SLTU = 5'b01100;

  localparam logic [IMM_W-1:0] IMM_I = 2'b00;
  localparam logic [IMM_W-1:0] IMM_S = 2'b01;
  localparam logic [IMM_W-1:0] IMM_B = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MULDIV = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_MULDIV = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } cls_t;

  state_t              state_q;
  cls_t                cls_q, cls_d;
  logic [FUNC_W-1:0]   alu_func_q, alu_func_d;
  logic                alu_sel_q, alu_sel_d;
  logic [IMM_W-1:0]    imm_sel_q, imm_sel_d;
  logic                res_sel_q, res_sel_d;
  logic                br_inv_q, br_inv_d;
  logic                illegal_q;
  logic                legal_d;
  logic [FUNC_W-1:0]   f3_func;
  logic                taken;

  // Shared func3 -> ALU function map for I-ALU and R-type (func3 != 000 for R)
  always_comb begin
    f3_func = ALU_ADD;
    case (func3)
      3'b000:  f3_func = ALU_ADD;
      3'b001:  f3_func = ALU_SLL;
      3'b010:  f3_func = ALU_SLT;
      3'b011:  f3_func = ALU_SLTU;
      3'b100:  f3_func = ALU_XOR;
      3'b101:  f3_func = ALU_SRL;
      3'b110:  f3_func = ALU_OR;
      default: f3_func = ALU_AND;
    endcase
  end

  // Instruction decode and legality check
  always_comb begin
    legal_d    = 1'b0;
    cls_d      = CLS_ALU;
    alu_func_d = ALU_ADD;
    alu_sel_d  = 1'b0;
    imm_sel_d  = IMM_I;
    res_sel_d  = 1'b0;
    br_inv_d   = 1'b0;
    case (opcode)
      OP_LOAD: begin
        if (func3 == 3'b010) begin
          legal_d   = 1'b1;
          cls_d     = CLS_LOAD;
          alu_sel_d = 1'b1;
          res_sel_d = 1'b1;
        end
      end
      OP_STORE: begin
        if (func3 == 3'b010) begin
          legal_d   = 1'b1;
          cls_d     = CLS_STORE;
          alu_sel_d = 1'b1;
          imm_sel_d = IMM_S;
        end
      end
      OP_IALU: begin
        legal_d    = 1'b1;
        alu_func_d = f3_func;
        alu_sel_d  = 1'b1;
      end
      OP_RTYPE: begin
        if (func3 == 3'b000) begin
          case (func7)
            7'b0000000: begin legal_d = 1'b1; alu_func_d = ALU_ADD; end
            7'b0100000: begin legal_d = 1'b1; alu_func_d = ALU_SUB; end
            7'b0010000: begin legal_d = 1'b1; alu_func_d = ALU_MUL; cls_d = CLS_MULDIV; end
            7'b0110000: begin legal_d = 1'b1; alu_func_d = ALU_DIV; cls_d = CLS_MULDIV; end
            default:    legal_d = 1'b0;
          endcase
        end else if (func7 == 7'b0000000) begin
          legal_d    = 1'b1;
          alu_func_d = f3_func;
        end
      end
      OP_BRANCH: begin
        // func3[0] selects the inverted-flag variant (bne/bge/bgeu)
        imm_sel_d = IMM_B;
        cls_d     = CLS_BRANCH;
        br_inv_d  = func3[0];
        case (func3)
          3'b000, 3'b001: begin legal_d = 1'b1; alu_func_d = ALU_SUB;  end
          3'b100, 3'b101: begin legal_d = 1'b1; alu_func_d = ALU_BLT;  end
          3'b110, 3'b111: begin legal_d = 1'b1; alu_func_d = ALU_SLTU; end
          default:        legal_d = 1'b0;
        endcase
      end
      default: legal_d = 1'b0;
    endcase
  end

  // State register, decode latches and sticky illegal flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      cls_q      <= CLS_ALU;
      alu_func_q <= '0;
      alu_sel_q  <= 1'b0;
      imm_sel_q  <= '0;
      res_sel_q  <= 1'b0;
      br_inv_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (legal_d) begin
            state_q    <= S_EXEC;
            cls_q      <= cls_d;
            alu_func_q <= alu_func_d;
            alu_sel_q  <= alu_sel_d;
            imm_sel_q  <= imm_sel_d;
            res_sel_q  <= res_sel_d;
            br_inv_q   <= br_inv_d;
          end else begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          case (cls_q)
            CLS_ALU:              state_q <= S_WB;
            CLS_MULDIV:           state_q <= S_MULDIV;
            CLS_LOAD, CLS_STORE:  state_q <= S_MEM;
            default:              state_q <= S_FETCH;
          endcase
        end
        S_MULDIV: begin
          if (alu_done) state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) state_q <= (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
        end
        S_WB:    state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign taken = alu_flag ^ br_inv_q;

  // Strobes: decoded from state, latched class and handshakes; rst forces them low
  always_comb begin
    Pc_We       = 1'b0;
    Ir_We       = 1'b0;
    Mem_Req     = 1'b0;
    We_Data_Mem = 1'b0;
    We_Reg      = 1'b0;
    Alu_Start   = 1'b0;
    Addr_Select = 1'b0;
    Pc_Select   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          Mem_Req = 1'b1;
          Ir_We   = mem_ready;
        end
        S_EXEC: begin
          Alu_Start = (cls_q == CLS_MULDIV);
          if (cls_q == CLS_BRANCH) begin
            Pc_We     = 1'b1;
            Pc_Select = taken;
          end
        end
        S_MEM: begin
          Mem_Req     = 1'b1;
          Addr_Select = 1'b1;
          We_Data_Mem = (cls_q == CLS_STORE);
          Pc_We       = (cls_q == CLS_STORE) && mem_ready;
        end
        S_WB: begin
          We_Reg = 1'b1;
          Pc_We  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Alu_Func      = alu_func_q;
  assign Alu_Select    = alu_sel_q;
  assign Imm_Select    = imm_sel_q;
  assign Result_Select = res_sel_q;
  assign Illegal       = illegal_q;
  assign State         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed bench for multicycle_controller. Each task walks one instruction
// cycle by cycle and compares State plus the strobe vector
// {Pc_We, Ir_We, Mem_Req, We_Data_Mem, We_Reg, Alu_Start, Addr_Select, Pc_Select}
// against hand-computed rows. Inputs change 1 ns after the rising edge and
// outputs are sampled 1 ns after that.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic       alu_flag = 1'b0;
  logic       alu_done = 1'b0;
  logic       mem_ready = 1'b0;
  logic       Pc_We, Ir_We, Mem_Req, We_Data_Mem, We_Reg, Alu_Start;
  logic       Addr_Select, Alu_Select, Result_Select, Pc_Select;
  logic [1:0] Imm_Select;
  logic [4:0] Alu_Func;
  logic       Illegal;
  logic [2:0] State;

  int checks = 0;
  int errors = 0;

  wire [7:0] strb = {Pc_We, Ir_We, Mem_Req, We_Data_Mem, We_Reg, Alu_Start, Addr_Select, Pc_Select};

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .alu_flag(alu_flag), .alu_done(alu_done), .mem_ready(mem_ready),
    .Pc_We(Pc_We), .Ir_We(Ir_We), .Mem_Req(Mem_Req), .We_Data_Mem(We_Data_Mem),
    .We_Reg(We_Reg), .Alu_Start(Alu_Start), .Addr_Select(Addr_Select),
    .Alu_Select(Alu_Select), .Result_Select(Result_Select), .Pc_Select(Pc_Select),
    .Imm_Select(Imm_Select), .Alu_Func(Alu_Func), .Illegal(Illegal), .State(State)
  );

  task automatic test_reset();
    mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (State !== 3'd0 || Illegal !== 1'b0 || strb !== 8'h00) begin
      errors++;
      $display("FAIL reset: state=%0d illegal=%b strobes=%b, want state=0 illegal=0 strobes=00000000", State, Illegal, strb);
    end
    checks++;
    if ({Alu_Func, Alu_Select, Imm_Select, Result_Select} !== 9'd0) begin
      errors++;
      $display("FAIL reset_fields: got %b, want 000000000", {Alu_Func, Alu_Select, Imm_Select, Result_Select});
    end
    rst = 1'b0;
  endtask

  // add with mem_ready high: FETCH, DECODE, EXEC, WB; next test's first row is cycle 5
  task automatic test_add();
    logic [11:0] rows [4] = '{{1'b1, 3'd0, 8'b0110_0000}, {1'b1, 3'd1, 8'h00},
                              {1'b1, 3'd2, 8'h00},        {1'b1, 3'd5, 8'b1000_1000}};
    opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0000000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rows[i][11]; #1;
      checks++;
      if (State !== rows[i][10:8] || strb !== rows[i][7:0]) begin
        errors++;
        $display("FAIL add row %0d: state=%0d strobes=%b, want state=%0d strobes=%b", i, State, strb, rows[i][10:8], rows[i][7:0]);
      end
      if (i == 2) begin
        checks++;
        if (Alu_Func !== 5'b00000 || Alu_Select !== 1'b0) begin
          errors++;
          $display("FAIL add_fields: func=%b asel=%b, want func=00000 asel=0", Alu_Func, Alu_Select);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // lw with 3 wait cycles in FETCH and in MEM
  task automatic test_lw_wait();
    logic [11:0] rows [11] = '{
      {1'b0, 3'd0, 8'b0010_0000}, {1'b0, 3'd0, 8'b0010_0000}, {1'b0, 3'd0, 8'b0010_0000},
      {1'b1, 3'd0, 8'b0110_0000}, {1'b1, 3'd1, 8'h00},        {1'b1, 3'd2, 8'h00},
      {1'b0, 3'd4, 8'b0010_0010}, {1'b0, 3'd4, 8'b0010_0010}, {1'b0, 3'd4, 8'b0010_0010},
      {1'b1, 3'd4, 8'b0010_0010}, {1'b1, 3'd5, 8'b1000_1000}};
    opcode = 7'b0000011; func3 = 3'b010; func7 = 7'b0000000;
    for (int i = 0; i < 11; i++) begin
      mem_ready = rows[i][11]; #1;
      checks++;
      if (State !== rows[i][10:8] || strb !== rows[i][7:0]) begin
        errors++;
        $display("FAIL lw row %0d: state=%0d strobes=%b, want state=%0d strobes=%b", i, State, strb, rows[i][10:8], rows[i][7:0]);
      end
      if (i == 5 || i == 10) begin
        checks++;
        if ({Alu_Func, Alu_Select, Imm_Select, Result_Select} !== {5'b00000, 1'b1, 2'b00, 1'b1}) begin
          errors++;
          $display("FAIL lw_fields row %0d: got %b, want 000001001", i, {Alu_Func, Alu_Select, Imm_Select, Result_Select});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [11:0] rows [4] = '{{1'b1, 3'd0, 8'b0110_0000}, {1'b1, 3'd1, 8'h00},
                              {1'b1, 3'd2, 8'h00},        {1'b1, 3'd4, 8'b1011_0010}};
    opcode = 7'b0100011; func3 = 3'b010; func7 = 7'b0000000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rows[i][11]; #1;
      checks++;
      if (State !== rows[i][10:8] || strb !== rows[i][7:0]) begin
        errors++;
        $display("FAIL sw row %0d: state=%0d strobes=%b, want state=%0d strobes=%b", i, State, strb, rows[i][10:8], rows[i][7:0]);
      end
      if (i == 2) begin
        checks++;
        if ({Alu_Func, Alu_Select, Imm_Select, Result_Select} !== {5'b00000, 1'b1, 2'b01, 1'b0}) begin
          errors++;
          $display("FAIL sw_fields: got %b, want 000001010", {Alu_Func, Alu_Select, Imm_Select, Result_Select});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // bge: not-taken flag (0) selects PC+imm, flag 1 selects PC+4
  task automatic test_bge();
    opcode = 7'b1100011; func3 = 3'b101; func7 = 7'b0000000;
    for (int pass = 0; pass < 2; pass++) begin
      logic [7:0] exec_strb;
      alu_flag  = (pass == 1);
      mem_ready = 1'b1;
      exec_strb = (pass == 0) ? 8'b1000_0001 : 8'b1000_0000;
      for (int i = 0; i < 3; i++) begin
        logic [2:0] exp_st;
        logic [7:0] exp_sb;
        exp_st = 3'(i);
        exp_sb = (i == 0) ? 8'b0110_0000 : (i == 1) ? 8'h00 : exec_strb;
        #1;
        checks++;
        if (State !== exp_st || strb !== exp_sb) begin
          errors++;
          $display("FAIL bge pass %0d row %0d: state=%0d strobes=%b, want state=%0d strobes=%b", pass, i, State, strb, exp_st, exp_sb);
        end
        if (i == 2) begin
          checks++;
          if (Alu_Func !== 5'b01000 || Imm_Select !== 2'b10 || Alu_Select !== 1'b0) begin
            errors++;
            $display("FAIL bge_fields: func=%b imm=%b asel=%b, want 01000 10 0", Alu_Func, Imm_Select, Alu_Select);
          end
        end
        @(posedge clk); #1;
      end
    end
    alu_flag = 1'b0;
  endtask

  // div: alu_done high outside MULDIV must be ignored; done after 10 MULDIV cycles
  task automatic test_div();
    opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0110000;
    mem_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      logic [2:0] exp_st;
      logic [7:0] exp_sb;
      alu_done = (i < 3) || (i == 13);
      if (i == 0)       begin exp_st = 3'd0; exp_sb = 8'b0110_0000; end
      else if (i == 1)  begin exp_st = 3'd1; exp_sb = 8'h00; end
      else if (i == 2)  begin exp_st = 3'd2; exp_sb = 8'b0000_0100; end
      else if (i < 14)  begin exp_st = 3'd3; exp_sb = 8'h00; end
      else              begin exp_st = 3'd5; exp_sb = 8'b1000_1000; end
      #1;
      checks++;
      if (State !== exp_st || strb !== exp_sb) begin
        errors++;
        $display("FAIL div row %0d: state=%0d strobes=%b, want state=%0d strobes=%b", i, State, strb, exp_st, exp_sb);
      end
      if (i == 2 || i == 12) begin
        checks++;
        if (Alu_Func !== 5'b00011 || Alu_Select !== 1'b0) begin
          errors++;
          $display("FAIL div_fields row %0d: func=%b asel=%b, want 00011 0", i, Alu_Func, Alu_Select);
        end
      end
      @(posedge clk); #1;
    end
    alu_done = 1'b0;
  endtask

  // xori with nonzero func7 bits: func7 ignored for I-ALU
  task automatic test_ialu();
    logic [11:0] rows [4] = '{{1'b1, 3'd0, 8'b0110_0000}, {1'b1, 3'd1, 8'h00},
                              {1'b1, 3'd2, 8'h00},        {1'b1, 3'd5, 8'b1000_1000}};
    opcode = 7'b0010011; func3 = 3'b100; func7 = 7'b1111111;
    for (int i = 0; i < 4; i++) begin
      mem_ready = rows[i][11]; #1;
      checks++;
      if (State !== rows[i][10:8] || strb !== rows[i][7:0]) begin
        errors++;
        $display("FAIL xori row %0d: state=%0d strobes=%b, want state=%0d strobes=%b", i, State, strb, rows[i][10:8], rows[i][7:0]);
      end
      if (i == 2) begin
        checks++;
        if ({Alu_Func, Alu_Select, Imm_Select, Result_Select} !== {5'b00110, 1'b1, 2'b00, 1'b0}) begin
          errors++;
          $display("FAIL xori_fields: got %b, want 001101000", {Alu_Func, Alu_Select, Imm_Select, Result_Select});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Several illegal encodings: each halts with no strobes until rst
  task automatic test_illegal();
    logic [16:0] enc [4] = '{{7'b1111111, 3'b000, 7'b0000000},
                             {7'b0110011, 3'b001, 7'b0000001},
                             {7'b0000011, 3'b000, 7'b0000000},
                             {7'b1100011, 3'b010, 7'b0000000}};
    for (int e = 0; e < 4; e++) begin
      {opcode, func3, func7} = enc[e];
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        logic [2:0] exp_st;
        logic [7:0] exp_sb;
        logic       exp_il;
        exp_st = (i == 0) ? 3'd0 : (i == 1) ? 3'd1 : 3'd7;
        exp_sb = (i == 0) ? 8'b0110_0000 : 8'h00;
        exp_il = (i >= 2);
        #1;
        checks++;
        if (State !== exp_st || strb !== exp_sb || Illegal !== exp_il) begin
          errors++;
          $display("FAIL illegal enc %0d row %0d: state=%0d strobes=%b illegal=%b, want %0d %b %b", e, i, State, strb, Illegal, exp_st, exp_sb, exp_il);
        end
        @(posedge clk); #1;
      end
      rst = 1'b1; #1;
      checks++;
      if (State !== 3'd0 || Illegal !== 1'b0 || strb !== 8'h00) begin
        errors++;
        $display("FAIL illegal_rst enc %0d: state=%0d illegal=%b strobes=%b, want 0 0 00000000", e, State, Illegal, strb);
      end
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  // rst mid-MEM of a load: immediate FETCH with strobes dropped, then clean restart
  task automatic test_rst_mid_mem();
    logic [11:0] rows [5] = '{{1'b1, 3'd0, 8'b0110_0000}, {1'b1, 3'd1, 8'h00},
                              {1'b1, 3'd2, 8'h00},        {1'b0, 3'd4, 8'b0010_0010},
                              {1'b0, 3'd4, 8'b0010_0010}};
    opcode = 7'b0000011; func3 = 3'b010; func7 = 7'b0000000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rows[i][11]; #1;
      checks++;
      if (State !== rows[i][10:8] || strb !== rows[i][7:0]) begin
        errors++;
        $display("FAIL rstmem row %0d: state=%0d strobes=%b, want state=%0d strobes=%b", i, State, strb, rows[i][10:8], rows[i][7:0]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    #1; rst = 1'b1; #1;
    checks++;
    if (State !== 3'd0 || strb !== 8'h00 || Illegal !== 1'b0) begin
      errors++;
      $display("FAIL rstmem_async: state=%0d strobes=%b illegal=%b, want 0 00000000 0", State, strb, Illegal);
    end
    checks++;
    if ({Alu_Func, Alu_Select, Imm_Select, Result_Select} !== 9'd0) begin
      errors++;
      $display("FAIL rstmem_fields: got %b, want 000000000", {Alu_Func, Alu_Select, Imm_Select, Result_Select});
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b1; #1;
    checks++;
    if (State !== 3'd0 || strb !== 8'b0110_0000) begin
      errors++;
      $display("FAIL rstmem_restart: state=%0d strobes=%b, want 0 01100000", State, strb);
    end
    @(posedge clk); #2;
    checks++;
    if (State !== 3'd1) begin
      errors++;
      $display("FAIL rstmem_decode: state=%0d, want 1", State);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_bge();
    test_div();
    test_ialu();
    test_illegal();
    test_rst_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
